// File: rtl/opb_simulink2ppc_bank.sv
// opb_simulink2ppc_bank: OPB slave exposing C_NUM_REGS captured 32-bit fabric words as a
// read-only bank. All channels load together on one user_valid strobe, so a set of reads
// sees a coherent sample. CTRL (0x80) holds a freeze bit, COUNT (0x84) counts captures.
// Optional feature macro: OPB_S2P_OVERRUN_EN adds a sticky W1C overrun flag at CTRL bit 30.
module opb_simulink2ppc_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_00FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 8,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [C_NUM_REGS*32-1:0]  user_data_in,
  input  logic                      user_valid
);

  localparam string unused_family = C_FAMILY;

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

  state_e      state_q;
  logic        ack_q;
  logic [31:0] dbus_q;
  logic        wr_ctrl_q, wr_count_q, wr_freeze_q;

  logic [31:0] shadow_q [C_NUM_REGS];
  logic [31:0] shadow_d [C_NUM_REGS];
  logic [31:0] count_q, count_d;
  logic        freeze_q, freeze_d;

  logic [31:0] abus, wdata, offset, word_idx, ctrl_word, rd_data;
  logic        hit, sel_shadow, sel_ctrl, sel_count, accept;

  assign abus     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = abus - C_BASEADDR;
  assign word_idx = {2'b00, offset[31:2]};

  assign hit        = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign sel_shadow = word_idx < C_NUM_REGS;
  assign sel_ctrl   = word_idx == 32'd32;
  assign sel_count  = word_idx == 32'd33;

`ifdef OPB_S2P_OVERRUN_EN
  logic overrun_q, overrun_d, wr_ovr_clr_q;
  logic unused_sigs;
  assign unused_sigs = ^{OPB_seqAddr, OPB_BE[0:2], offset[1:0], wdata[31:2]};
  assign ctrl_word   = {30'd0, overrun_q, freeze_q};
`else
  logic unused_sigs;
  assign unused_sigs = ^{OPB_seqAddr, OPB_BE[0:2], offset[1:0], wdata[31:1]};
  assign ctrl_word   = {31'd0, freeze_q};
`endif

  // Read mux, evaluated at the decode edge; unmapped in-window offsets read as zero.
  always_comb begin
    rd_data = '0;
    if (sel_shadow) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
        if (word_idx == i) rd_data = shadow_q[i];
      end
    end else if (sel_ctrl) begin
      rd_data = ctrl_word;
    end else if (sel_count) begin
      rd_data = count_q;
    end
  end

  // A request still present in the hold cycle is accepted, giving one ack every two cycles.
  assign accept = OPB_select && hit && ((state_q == StIdle) || (state_q == StHold));

  // Bus FSM with registered ack/data; write intent is latched at decode, applied after ACK.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q      <= StIdle;
      ack_q        <= 1'b0;
      dbus_q       <= '0;
      wr_ctrl_q    <= 1'b0;
      wr_count_q   <= 1'b0;
      wr_freeze_q  <= 1'b0;
`ifdef OPB_S2P_OVERRUN_EN
      wr_ovr_clr_q <= 1'b0;
`endif
    end else begin
      ack_q       <= 1'b0;
      dbus_q      <= '0;
      wr_ctrl_q   <= 1'b0;
      wr_count_q  <= 1'b0;
      wr_freeze_q <= 1'b0;
`ifdef OPB_S2P_OVERRUN_EN
      wr_ovr_clr_q <= 1'b0;
`endif
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            state_q     <= StAck;
            ack_q       <= 1'b1;
            dbus_q      <= OPB_RNW ? rd_data : 32'd0;
            wr_ctrl_q   <= !OPB_RNW && sel_ctrl && OPB_BE[3];
            wr_count_q  <= !OPB_RNW && sel_count;
            wr_freeze_q <= wdata[0];
`ifdef OPB_S2P_OVERRUN_EN
            wr_ovr_clr_q <= !OPB_RNW && sel_ctrl && OPB_BE[3] && wdata[1];
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StAck:   state_q <= StHold;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Capture and register side effects; the capture sees freeze before a same-edge write.
  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    freeze_d = freeze_q;
    if (user_valid && !freeze_q) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
        shadow_d[i] = user_data_in[32*i +: 32];
      end
      count_d = count_q + 32'd1;
    end
    // Clear beats a same-edge increment.
    if (wr_count_q) count_d = '0;
    if (wr_ctrl_q)  freeze_d = wr_freeze_q;
  end

`ifdef OPB_S2P_OVERRUN_EN
  // Sticky overrun: a same-edge set beats the W1C clear.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_ovr_clr_q)            overrun_d = 1'b0;
    if (user_valid && freeze_q)  overrun_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) overrun_q <= 1'b0;
    else         overrun_q <= overrun_d;
  end
`endif

  // Shadow bank, capture counter and freeze state.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      shadow_q <= '{default: '0};
      count_q  <= '0;
      freeze_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
      freeze_q <= freeze_d;
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
